// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - opcode and format-code constants for the immediate generator
package imm_gen_pkg;

    typedef logic [2:0] fmt_t;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    localparam fmt_t FMT_R   = 3'd0;
    localparam fmt_t FMT_I   = 3'd1;
    localparam fmt_t FMT_S   = 3'd2;
    localparam fmt_t FMT_B   = 3'd3;
    localparam fmt_t FMT_U   = 3'd4;
    localparam fmt_t FMT_J   = 3'd5;
    localparam fmt_t FMT_ILL = 3'd7;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// rtl/imm_gen_pipe_decode.sv - combinational instruction to immediate/format decoder
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    // every format is first assembled as a 32-bit sign-extended value
    logic signed [31:0] imm32;

    // opcode decode; unknown opcodes and non-32-bit encodings fall through as illegal
    always_comb begin
        imm32   = '0;
        fmt     = FMT_ILL;
        illegal = 1'b1;
        if (instr[1:0] == 2'b11) begin
            case (instr[6:0])
                OP_IMM, LOAD, JALR, SYSTEM: begin
                    imm32   = {{20{instr[31]}}, instr[31:20]};
                    fmt     = FMT_I;
                    illegal = 1'b0;
                end
                STORE: begin
                    imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                    fmt     = FMT_S;
                    illegal = 1'b0;
                end
                BRANCH: begin
                    imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                    fmt     = FMT_B;
                    illegal = 1'b0;
                end
                LUI, AUIPC: begin
                    imm32   = {instr[31:12], 12'b0};
                    fmt     = FMT_U;
                    illegal = 1'b0;
                end
                JAL: begin
                    imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                    fmt     = FMT_J;
                    illegal = 1'b0;
                end
                OP: begin
                    imm32   = '0;
                    fmt     = FMT_R;
                    illegal = 1'b0;
                end
                default: begin
                    imm32   = '0;
                    fmt     = FMT_ILL;
                    illegal = 1'b1;
                end
            endcase
        end
    end

    // widening a signed value replicates bit 31 up to XLEN
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - buffered RISC-V immediate generator with result FIFO
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_imm,
    output logic [2:0]               out_fmt,
    output logic                     out_illegal,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;

    logic [XLEN-1:0] imm_mem   [DEPTH];
    logic [2:0]      fmt_mem   [DEPTH];
    logic            ill_mem   [DEPTH];
    logic [31:0]     instr_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign in_ready  = (level < LW'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // pointers and occupancy; reset beats flush, flush discards same-cycle traffic
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // capture the decoded result into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            imm_mem[wr_ptr]   <= dec_imm;
            fmt_mem[wr_ptr]   <= dec_fmt;
            ill_mem[wr_ptr]   <= dec_illegal;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    // head entry, forced to zero while empty so stale slots never leak out
    always_comb begin
        out_imm     = '0;
        out_fmt     = '0;
        out_illegal = 1'b0;
        out_instr   = '0;
        if (out_valid) begin
            out_imm     = imm_mem[rd_ptr];
            out_fmt     = fmt_mem[rd_ptr];
            out_illegal = ill_mem[rd_ptr];
            out_instr   = instr_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard testbench for imm_gen_pipe
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid64 = 1'b0;
    logic [31:0] in_instr = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_imm, out_instr;
    logic [2:0]  out_fmt, level;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [31:0] out_instr64;
    logic [2:0]  out_fmt64, level64;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq[$];
    exp_t e;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_instr(out_instr),
        .level(level)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_instr(out_instr64),
        .level(level64)
    );

    // independent reference: arithmetic shifts of the sign-extended word
    function automatic exp_t model(input logic [31:0] i);
        exp_t r;
        logic signed [63:0] w;
        w = {{32{i[31]}}, i};
        r.instr = i;
        r.imm = '0;
        r.fmt = 3'd7;
        r.ill = 1'b1;
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h73: begin r.imm = w >>> 20; r.fmt = 3'd1; r.ill = 1'b0; end
            7'h23: begin r.imm = ((w >>> 25) <<< 5) | 64'(i[11:7]); r.fmt = 3'd2; r.ill = 1'b0; end
            7'h63: begin
                r.imm = ((w >>> 31) <<< 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5) | (64'(i[11:8]) << 1);
                r.fmt = 3'd3; r.ill = 1'b0;
            end
            7'h37, 7'h17: begin r.imm = w & ~64'hFFF; r.fmt = 3'd4; r.ill = 1'b0; end
            7'h6F: begin
                r.imm = ((w >>> 31) <<< 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11) | (64'(i[30:21]) << 1);
                r.fmt = 3'd5; r.ill = 1'b0;
            end
            7'h33: begin r.imm = '0; r.fmt = 3'd0; r.ill = 1'b0; end
            default: ;
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        vectors++;
        if ({level, out_valid, in_ready} !== {3'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_flags: got level=%0d valid=%b ready=%b want 0 0 1", level, out_valid, in_ready);
        end
        vectors++;
        if ({out_imm, out_fmt, out_illegal, out_instr} !== 68'd0) begin
            miscompares++;
            $display("FAIL reset_data: got imm=%h fmt=%0d ill=%b instr=%h want all 0", out_imm, out_fmt, out_illegal, out_instr);
        end
        vectors++;
        if ({level64, out_valid64, out_imm64} !== 68'd0) begin
            miscompares++;
            $display("FAIL reset_64: got level=%0d valid=%b imm=%h want 0", level64, out_valid64, out_imm64);
        end
    endtask

    task automatic test_formats();
        logic [31:0] vi [8] = '{32'h01500013, 32'h81500003, 32'hFF001023, 32'h000000E3,
                                32'h2ED80037, 32'hD545506F, 32'hD2B75DB3, 32'h00000000};
        logic [31:0] vm [8] = '{32'h00000015, 32'hFFFFF815, 32'hFFFFFFE0, 32'h00000800,
                                32'h2ED80000, 32'hFFF55554, 32'h00000000, 32'h00000000};
        logic [2:0]  vf [8] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd7};
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_instr = vi[k];
            out_ready = 1'b0;
            sbq.push_back('{instr: vi[k], imm: {32'h0, vm[k]}, fmt: vf[k], ill: (k == 7)});
            step();
            in_valid = 1'b0;
            e = sbq.pop_front();
            vectors++;
            if ({out_valid, out_instr, out_imm, out_fmt, out_illegal} !== {1'b1, e.instr, e.imm[31:0], e.fmt, e.ill}) begin
                miscompares++;
                $display("FAIL fmt_%0d: got v=%b instr=%h imm=%h fmt=%0d ill=%b want 1 %h %h %0d %b",
                         k, out_valid, out_instr, out_imm, out_fmt, out_illegal, e.instr, e.imm[31:0], e.fmt, e.ill);
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            vectors++;
            if ({level, out_valid} !== {3'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL fmt_pop_%0d: got level=%0d valid=%b want 0 0", k, level, out_valid);
            end
        end
    endtask

    task automatic test_xlen64();
        in_valid64 = 1'b1;
        in_instr = 32'hB1500073;
        step();
        in_valid64 = 1'b0;
        vectors++;
        if ({out_valid64, out_imm64, out_fmt64, out_illegal64} !== {1'b1, 64'hFFFFFFFFFFFFFB15, 3'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL xlen64: got v=%b imm=%h fmt=%0d ill=%b want 1 fffffffffffffb15 1 0",
                     out_valid64, out_imm64, out_fmt64, out_illegal64);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (level64 !== 3'd0) begin
            miscompares++;
            $display("FAIL xlen64_pop: got level=%0d want 0", level64);
        end
    endtask

    task automatic test_full();
        logic [31:0] vi [4] = '{32'h7FF00093, 32'hFE112E23, 32'h800000B7, 32'h8000006F};
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_instr = vi[k];
            sbq.push_back(model(vi[k]));
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if ({level, in_ready} !== {3'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL full_flags: got level=%0d ready=%b want 4 0", level, in_ready);
        end
        in_valid = 1'b1;
        in_instr = 32'h12345013;
        step();
        vectors++;
        if (level !== 3'd4) begin
            miscompares++;
            $display("FAIL full_drop: got level=%0d want 4", level);
        end
        out_ready = 1'b1;
        e = sbq.pop_front();
        vectors++;
        if ({out_instr, out_imm, out_fmt, out_illegal} !== {e.instr, e.imm[31:0], e.fmt, e.ill}) begin
            miscompares++;
            $display("FAIL full_head: got instr=%h imm=%h want %h %h", out_instr, out_imm, e.instr, e.imm[31:0]);
        end
        step();
        in_valid = 1'b0;
        vectors++;
        if ({level, in_ready} !== {3'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL full_pop: got level=%0d ready=%b want 3 1", level, in_ready);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            vectors++;
            if ({out_valid, out_instr, out_imm, out_fmt, out_illegal} !== {1'b1, e.instr, e.imm[31:0], e.fmt, e.ill}) begin
                miscompares++;
                $display("FAIL drain: got v=%b instr=%h imm=%h fmt=%0d want 1 %h %h %0d",
                         out_valid, out_instr, out_imm, out_fmt, e.instr, e.imm[31:0], e.fmt);
            end
            step();
        end
        out_ready = 1'b0;
        vectors++;
        if ({level, out_valid} !== {3'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL drain_empty: got level=%0d valid=%b want 0 0", level, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [6] = '{7'h13, 7'h23, 7'h63, 7'h37, 7'h6F, 7'h03};
        logic [31:0] r;
        r = {$urandom_range(0, 32'h1FFFFFF), 7'h67};
        in_valid = 1'b1;
        in_instr = r;
        sbq.push_back(model(r));
        out_ready = 1'b0;
        step();
        for (int k = 0; k < 7; k++) begin
            r = {$urandom_range(0, 32'h1FFFFFF), ops[k % 6]};
            in_instr = r;
            sbq.push_back(model(r));
            out_ready = 1'b1;
            e = sbq.pop_front();
            vectors++;
            if ({out_valid, out_instr, out_imm, out_fmt, out_illegal} !== {1'b1, e.instr, e.imm[31:0], e.fmt, e.ill}) begin
                miscompares++;
                $display("FAIL b2b_%0d: got instr=%h imm=%h fmt=%0d want %h %h %0d",
                         k, out_instr, out_imm, out_fmt, e.instr, e.imm[31:0], e.fmt);
            end
            step();
            vectors++;
            if (level !== 3'd1) begin
                miscompares++;
                $display("FAIL b2b_level_%0d: got %0d want 1", k, level);
            end
        end
        in_valid = 1'b0;
        e = sbq.pop_front();
        vectors++;
        if ({out_instr, out_imm} !== {e.instr, e.imm[31:0]}) begin
            miscompares++;
            $display("FAIL b2b_last: got instr=%h imm=%h want %h %h", out_instr, out_imm, e.instr, e.imm[31:0]);
        end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_flush(input logic use_reset);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_instr = 32'h00100093 + 32'(k << 20);
            step();
        end
        vectors++;
        if (level !== 3'd3) begin
            miscompares++;
            $display("FAIL flush_fill_%0d: got level=%0d want 3", use_reset, level);
        end
        in_instr = 32'h0FF00013;
        if (use_reset) rst_n = 1'b0;
        else flush = 1'b1;
        step();
        in_valid = 1'b0;
        flush = 1'b0;
        rst_n = 1'b1;
        vectors++;
        if ({level, out_valid, in_ready, out_imm, out_instr} !== {3'd0, 1'b0, 1'b1, 64'd0}) begin
            miscompares++;
            $display("FAIL flush_%0d: got level=%0d valid=%b ready=%b imm=%h instr=%h want 0 0 1 0 0",
                     use_reset, level, out_valid, in_ready, out_imm, out_instr);
        end
        in_valid = 1'b1;
        in_instr = 32'h01500013;
        step();
        in_valid = 1'b0;
        vectors++;
        if ({level, out_instr, out_imm} !== {3'd1, 32'h01500013, 32'h15}) begin
            miscompares++;
            $display("FAIL flush_after_%0d: got level=%0d instr=%h imm=%h want 1 01500013 15",
                     use_reset, level, out_instr, out_imm);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_formats();
        test_xlen64();
        test_full();
        test_back_to_back();
        test_flush(1'b0);
        test_flush(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, buffered RISC-V immediate generator for the pipelined processor.
- Accepts 32-bit instructions over a valid/ready handshake and decodes format and sign-extended immediate at XLEN width (RV32/RV64).
- Flags illegal encodings and queues results in a small FIFO, so the execute stage can apply back-pressure without stalling fetch.
- Sits between the fetch stage and the register-read/execute stage.

Parameters:
- XLEN, 32, immediate output width; legal values 32 or 64.
- DEPTH, 4, result FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  synchronous discard of all queued entries
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept an instruction
- in_instr  in  32  raw instruction word
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head entry
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  format code: 0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
- out_illegal  out  1  head instruction illegal
- out_instr  out  32  instruction passed through unchanged
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n=0 at a clk edge) clears occupancy and read/write pointers. After reset:
  - level=0, out_valid=0, in_ready=1.
  - out_imm, out_fmt, out_illegal and out_instr all read 0.
  - Reset has priority over flush and over any handshake.
- Decode is combinational on in_instr and is captured into the FIFO on push (in_valid && in_ready).
- Immediate rules:
  - I-type (opcodes 0010011, 0000011, 1100111, 1110011): sext(instr[31:20]).
  - S-type (0100011): sext({instr[31:25], instr[11:7]}).
  - B-type (1100011): sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U-type (0110111, 0010111): sext({instr[31:12], 12'b0}).
  - J-type (1101111): sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R-type (0110011): imm=0, fmt=0, not illegal.
  - Any other opcode, or instr[1:0]≠2'b11: illegal=1, fmt=7, imm=0.
  - Sign extension is always from the instruction's bit 31 up to XLEN.
- Handshake:
  - in_ready = (level < DEPTH); it is a function of registered state only, with no combinational path from out_ready.
  - out_valid = (level ≠ 0).
  - Pop occurs on out_valid && out_ready.
- Latency: an instruction pushed into an empty FIFO appears on the outputs in the cycle after the push edge (1 cycle). There is no bypass.
- Simultaneous push and pop (level not full, not empty): level is unchanged and both pointers advance.
- Full: in_ready=0, and a push is ignored even if a pop occurs in the same cycle. in_ready returns to 1 the cycle after the pop.
- Empty: out_ready is ignored; all out_* data fields read 0.
- Pointer wrap: pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy is tracked in the separate level counter.
- Flush: at the clock edge with flush=1, level becomes 0 and both pointers reset. A push or pop in the same cycle is discarded.
- Outputs hold stable while out_valid && !out_ready.

Decomposition:
- Package imm_gen_pkg holds:
  - opcode localparams (OP_IMM, LOAD, JALR, SYSTEM, STORE, BRANCH, LUI, AUIPC, JAL, OP).
  - fmt code constants FMT_R..FMT_ILL.
- Sub-module imm_decode (combinational, parametrised by XLEN): instr → {imm, fmt, illegal}.
- imm_gen_pipe instantiates imm_decode and owns the FIFO storage, pointers and level counter.

Test Plan:
- Reset and single decodes:
  - Reset, then push 0x01500013 → one cycle later out_valid=1, out_imm=0x00000015, out_fmt=1, out_illegal=0.
  - Push 0x81500003 → out_imm=0xFFFFF815, out_fmt=1.
- Immediate formats at XLEN=32:
  - 0xFF001023 → out_imm=0xFFFFFFE0, fmt=2.
  - 0x000000E3 → out_imm=0x00000800, fmt=3.
  - 0x2ED80037 → out_imm=0x2ED80000, fmt=4.
  - 0xD545506F → out_imm=0xFFF55554, fmt=5.
  - 0xD2B75DB3 → out_imm=0, fmt=0.
- XLEN=64: push 0xB1500073 → out_imm=0xFFFFFFFFFFFFFB15, fmt=1.
- Illegal encoding: push 0x00000000 → out_illegal=1, fmt=7, imm=0.
- Back-pressure and full:
  - Hold out_ready=0 and push DEPTH instructions → level=4, in_ready=0; a fifth push is dropped.
  - Release out_ready → entries drain in order, and in_ready=1 the cycle after the first pop.
- Flush and reset mid-operation:
  - With level=3, assert flush together with in_valid → next cycle level=0, out_valid=0, and the pushed instruction is lost.
  - Repeat with rst_n=0 → same result.
